// File: rtl/aes_key_expander_if.sv
// Subkey stream between the AES-128 key schedule and add_round_keys.
// master: drives subkey/subkey_valid/round_idx, reads subkey_ready.
interface aes_key_expander_if;
  logic [127:0] subkey;
  logic         subkey_valid;
  logic         subkey_ready;
  logic [3:0]   round_idx;

  modport master (
    output subkey,
    output subkey_valid,
    output round_idx,
    input  subkey_ready
  );

  modport slave (
    input  subkey,
    input  subkey_valid,
    input  round_idx,
    output subkey_ready
  );
endinterface

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule streaming round keys 0..10, one per handshake.
// Ports: clk, rst_n, key_in, key_load, [rev], kx (subkey master), busy, done.
// AES_KEYEXP_REVERSE_EN adds rev: precompute round 10, then emit 10 down to 0.
module aes_key_expander #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [127:0]         key_in,
  input  logic                 key_load,
`ifdef AES_KEYEXP_REVERSE_EN
  input  logic                 rev,
`endif
  aes_key_expander_if.master   kx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

`ifdef AES_KEYEXP_REVERSE_EN
  typedef enum logic [1:0] {IDLE, EMIT, PRE} state_t;
`else
  typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

  state_t       state;
  logic [127:0] key_q;
  logic [3:0]   round_q;
  logic         valid_q;
  logic         busy_q;
  logic         done_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the field inverse and maps 0 to 0 for free.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] t;
    t = a;
    for (int i = 0; i < 6; i++)
      t = gmul(gmul(t, t), a);
    return gmul(t, t);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sw_in, rot, sw, rc;
  logic [31:0]  f0, f1, f2, f3;
  logic [31:0]  i0, i1, i2, i3;
  logic         inv_step;
  logic         last;
  logic [127:0] next_key;
  logic [3:0]   next_idx;

`ifdef AES_KEYEXP_REVERSE_EN
  logic rev_q;
  assign inv_step = rev_q && (state == EMIT);
`else
  assign inv_step = 1'b0;
`endif

  assign {w0, w1, w2, w3} = key_q;

  // One shared SubWord: the inverse step feeds the recovered w3.
  assign sw_in = inv_step ? (w3 ^ w2) : w3;
  assign rot   = {sw_in[23:0], sw_in[31:24]};
  assign sw    = {sbox(rot[31:24]), sbox(rot[23:16]),
                  sbox(rot[15:8]),  sbox(rot[7:0])};
  assign rc    = {rcon(inv_step ? round_q : round_q + 4'd1),
                  24'h0};

  assign f0 = w0 ^ sw ^ rc;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign i3 = w3 ^ w2;
  assign i2 = w2 ^ w1;
  assign i1 = w1 ^ w0;
  assign i0 = w0 ^ sw ^ rc;

  assign next_key = inv_step ? {i0, i1, i2, i3}
                             : {f0, f1, f2, f3};
  assign next_idx = inv_step ? round_q - 4'd1
                             : round_q + 4'd1;
  assign last     = inv_step ? (round_q == 4'd0)
                             : (round_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AES_KEYEXP_REVERSE_EN
      rev_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (key_load) begin
        key_q   <= key_in;
        round_q <= '0;
        busy_q  <= 1'b1;
`ifdef AES_KEYEXP_REVERSE_EN
        rev_q   <= rev;
        if (rev) begin
          state   <= PRE;
          valid_q <= 1'b0;
        end else begin
          state   <= EMIT;
          valid_q <= 1'b1;
        end
`else
        state   <= EMIT;
        valid_q <= 1'b1;
`endif
      end else begin
        case (state)
          EMIT: begin
            if (valid_q && kx.subkey_ready) begin
              if (last) begin
                state   <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                key_q   <= next_key;
                round_q <= next_idx;
              end
            end
          end
`ifdef AES_KEYEXP_REVERSE_EN
          PRE: begin
            key_q   <= next_key;
            round_q <= next_idx;
            if (round_q == LAST - 4'd1) begin
              state   <= EMIT;
              valid_q <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign kx.subkey       = key_q;
  assign kx.subkey_valid = valid_q;
  assign kx.round_idx    = round_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
